// File: rtl/board_state.sv
// 8x8 minesweeper board state: mine/flag/step maps, cursor, a flood-reveal
// sweep engine and win/loss tracking, plus redraw requests for a display.
module board_state #(
  parameter int WRAP_CURSOR = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_mines,
  input  logic [63:0] mine_seed,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        flag_req,
  input  logic        step_req,
  input  logic [5:0]  count_tile,
  output logic [63:0] mineMap,
  output logic [63:0] flagMap,
  output logic [63:0] stepMap,
  output logic [5:0]  cursor,
  output logic [3:0]  count_out,
  output logic        busy,
  output logic        game_over,
  output logic        game_won,
  output logic        upd_valid,
  output logic [5:0]  upd_tile,
  output logic        upd_all
);

  typedef enum logic [1:0] {IDLE, SWEEP, LOST, WON} state_e;

  state_e      state_q;
  logic [63:0] mine_q, flag_q, step_q;
  logic [5:0]  cursor_q, upd_tile_q, idx_q;
  logic        busy_q, over_q, won_q, upd_valid_q, upd_all_q, revealed_q;

  logic [2:0]  row_d, col_d;
  logic [5:0]  cursor_d;
  logic [3:0]  tile_cnt [64];
  logic [63:0] zero_stepped, nb_zero;
  logic [3:0]  cur_cnt;
  logic        any_move, reveal_now, step_won, sweep_won;

  // Bitmask of the up-to-8 tiles surrounding tile t, without edge wrap.
  function automatic logic [63:0] nb_mask(input int t);
    logic [63:0] m;
    int r, c;
    m = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = t / 8 + dr;
        c = t % 8 + dc;
        if ((dr != 0 || dc != 0) && r >= 0 && r < 8 && c >= 0 && c < 8)
          m = m | (64'd1 << (r * 8 + c));
      end
    end
    return m;
  endfunction

  for (genvar gi = 0; gi < 64; gi++) begin : g_tile
    localparam logic [63:0] NB = nb_mask(gi);
    assign tile_cnt[gi]     = 4'($countones(mine_q & NB));
    assign zero_stepped[gi] = step_q[gi] && (tile_cnt[gi] == 4'd0);
    assign nb_zero[gi]      = |(zero_stepped & NB);
  end

  always_comb begin
    row_d = cursor_q[5:3];
    col_d = cursor_q[2:0];
    if (move_up) begin
      if (row_d != 3'd0)           row_d = row_d - 3'd1;
      else if (WRAP_CURSOR != 0)   row_d = 3'd7;
    end else if (move_down) begin
      if (row_d != 3'd7)           row_d = row_d + 3'd1;
      else if (WRAP_CURSOR != 0)   row_d = 3'd0;
    end else if (move_left) begin
      if (col_d != 3'd0)           col_d = col_d - 3'd1;
      else if (WRAP_CURSOR != 0)   col_d = 3'd7;
    end else if (move_right) begin
      if (col_d != 3'd7)           col_d = col_d + 3'd1;
      else if (WRAP_CURSOR != 0)   col_d = 3'd0;
    end
    cursor_d = {row_d, col_d};
  end

  assign any_move   = move_up | move_down | move_left | move_right;
  assign cur_cnt    = tile_cnt[cursor_q];
  assign reveal_now = (state_q == SWEEP) && !step_q[idx_q] && !flag_q[idx_q]
                      && !mine_q[idx_q] && nb_zero[idx_q];
  // Win test for the cycle a step lands: include the tile being stepped.
  assign step_won   = ((~mine_q & ~(step_q | (64'd1 << cursor_q))) == 64'd0);
  assign sweep_won  = ((~mine_q & ~step_q) == 64'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mine_q      <= '0;
      flag_q      <= '0;
      step_q      <= '0;
      cursor_q    <= '0;
      upd_tile_q  <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
      won_q       <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_all_q   <= 1'b0;
      revealed_q  <= 1'b0;
    end else begin
      upd_valid_q <= 1'b0;
      upd_all_q   <= 1'b0;
      if (load_mines) begin
        state_q    <= IDLE;
        mine_q     <= mine_seed;
        flag_q     <= '0;
        step_q     <= '0;
        cursor_q   <= '0;
        idx_q      <= '0;
        busy_q     <= 1'b0;
        over_q     <= 1'b0;
        won_q      <= 1'b0;
        revealed_q <= 1'b0;
        upd_all_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            // Only the highest-priority asserted command is considered.
            if (step_req) begin
              if (!flag_q[cursor_q] && !step_q[cursor_q]) begin
                step_q[cursor_q] <= 1'b1;
                upd_valid_q      <= 1'b1;
                upd_tile_q       <= cursor_q;
                if (mine_q[cursor_q]) begin
                  state_q <= LOST;
                  over_q  <= 1'b1;
                end else if (cur_cnt == 4'd0) begin
                  state_q    <= SWEEP;
                  busy_q     <= 1'b1;
                  idx_q      <= '0;
                  revealed_q <= 1'b0;
                end else if (step_won) begin
                  state_q <= WON;
                  won_q   <= 1'b1;
                end
              end
            end else if (flag_req) begin
              if (!step_q[cursor_q]) begin
                flag_q[cursor_q] <= ~flag_q[cursor_q];
                upd_valid_q      <= 1'b1;
                upd_tile_q       <= cursor_q;
              end
            end else if (any_move) begin
              cursor_q <= cursor_d;
            end
          end
          SWEEP: begin
            if (reveal_now) begin
              step_q[idx_q] <= 1'b1;
              upd_valid_q   <= 1'b1;
              upd_tile_q    <= idx_q;
            end
            if (idx_q == 6'd63) begin
              idx_q      <= '0;
              revealed_q <= 1'b0;
              // A quiet pass means the flood has reached its fixpoint.
              if (!(revealed_q || reveal_now)) begin
                busy_q <= 1'b0;
                if (sweep_won) begin
                  state_q <= WON;
                  won_q   <= 1'b1;
                end else begin
                  state_q <= IDLE;
                end
              end
            end else begin
              idx_q      <= idx_q + 6'd1;
              revealed_q <= revealed_q | reveal_now;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mineMap   = mine_q;
  assign flagMap   = flag_q;
  assign stepMap   = step_q;
  assign cursor    = cursor_q;
  assign count_out = tile_cnt[count_tile];
  assign busy      = busy_q;
  assign game_over = over_q;
  assign game_won  = won_q;
  assign upd_valid = upd_valid_q;
  assign upd_tile  = upd_tile_q;
  assign upd_all   = upd_all_q;

endmodule

// File: doc/board_state.md
BOARD_STATE -- requirements
Module: board_state

Interface
REQ-001 SHALL have parameter WRAP_CURSOR, default 0; 0 = cursor saturates at board edges, 1 = cursor wraps within its row/column.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port load_mines, input, 1, one-cycle pulse that starts a new game from mine_seed.
REQ-005 SHALL have port mine_seed, input, 64, mine layout captured on load_mines.
REQ-006 SHALL have ports move_up, move_down, move_left, move_right, input, 1 each, one-cycle cursor move pulses.
REQ-007 SHALL have ports flag_req and step_req, input, 1 each, one-cycle command pulses applied at the cursor tile.
REQ-008 SHALL have port count_tile, input, 6, tile address for the neighbour-count read port.
REQ-009 SHALL have ports mineMap, flagMap, stepMap, output, 64 each, registered board maps; bit n = tile n.
REQ-010 SHALL have port cursor, output, 6, registered cursor tile.
REQ-011 SHALL have port count_out, output, 4, combinational count (0-8) of mines adjacent to count_tile.
REQ-012 SHALL have ports busy, game_over, game_won, output, 1 each, registered status.
REQ-013 SHALL have ports upd_valid (1), upd_tile (6), upd_all (1), outputs, registered redraw requests.

Function
REQ-014 SHALL number tiles as {row[2:0], col[2:0]}, row 0 at the top and col 0 at the left; neighbours are the up-to-8 tiles at row/col distance 1, with no wrap across edges.
REQ-015 SHALL implement FSM states IDLE, SWEEP, LOST and WON.
REQ-016 SHALL, on load_mines in any state, load mineMap from mine_seed, clear flagMap and stepMap, set cursor to 0, clear status, pulse upd_all, and enter IDLE next cycle.
REQ-017 SHALL give load_mines priority over every other input, then step_req, then flag_req, then moves (up, down, left, right); at most one command SHALL act per cycle.
REQ-018 SHALL, in IDLE, apply a move one cycle after the pulse: row-1 for up, row+1 for down, col-1 for left, col+1 for right; at an edge the cursor SHALL hold when WRAP_CURSOR=0 and SHALL wrap 0<->7 when WRAP_CURSOR=1.
REQ-019 SHALL, in IDLE, toggle flagMap[cursor] on flag_req only when stepMap[cursor]=0, and SHALL pulse upd_valid with upd_tile=cursor when it toggles.
REQ-020 SHALL ignore step_req when flagMap[cursor]=1 or stepMap[cursor]=1.
REQ-021 SHALL, on an accepted step of a mine, set stepMap[cursor], pulse upd_valid, and enter LOST with game_over=1.
REQ-022 SHALL, on an accepted step of a safe tile, set stepMap[cursor] and pulse upd_valid; if that tile's neighbour count is 0 it SHALL enter SWEEP with busy=1 on the next cycle, otherwise it SHALL perform the win check (REQ-025) and stay in IDLE.
REQ-023 SHALL, in SWEEP, examine one tile per cycle at index 0..63. A tile SHALL be revealed (stepMap bit set, upd_valid pulsed with that tile) when it is unstepped, unflagged, not a mine, and has a stepped neighbour whose count is 0.
REQ-024 SHALL, at index 63 of a SWEEP pass, start a new pass at index 0 if any tile was revealed during the pass; otherwise it SHALL return to IDLE with busy=0 and perform the win check.
REQ-025 SHALL enter WON with game_won=1 when (~mineMap & ~stepMap) == 0, evaluated only after a step or sweep completes.
REQ-026 SHALL ignore every input except load_mines while in SWEEP, LOST or WON.
REQ-027 SHALL make upd_valid and upd_all one-cycle pulses that are 0 otherwise; upd_tile SHALL hold its last value.

Reset
REQ-028 SHALL, while resetn=0, force all maps to 0, cursor, upd_tile and count index to 0, busy, game_over, game_won, upd_valid and upd_all to 0, and the FSM to IDLE, including when reset is asserted mid-SWEEP.

Verification
REQ-029 SHALL cover: reset, then load_mines with seed 0x1 (mine at tile 0), move_right, step_req -> cursor=1, stepMap=0x2, count_out(count_tile=1)=1, busy never 1.
REQ-030 SHALL cover: cursor at 5, flag_req twice -> flagMap bit5 goes 1 then 0 with an upd_valid pulse each time; with bit5 set, step_req -> no change to stepMap.
REQ-031 SHALL cover: mine at tile 9, move_down then move_right, step_req -> stepMap=0x200, game_over=1; a later move_left leaves cursor=9.
REQ-032 SHALL cover: seed 0x8000000000000000, step tile 0 -> busy=1 for at least 128 cycles, final stepMap=0x7FFFFFFFFFFFFFFF, game_won=1.
REQ-033 SHALL cover: move_up/move_left at cursor 0 -> cursor=0 with WRAP_CURSOR=0; move_left at cursor 0 -> cursor=7 with WRAP_CURSOR=1.
REQ-034 SHALL cover: resetn pulsed low during SWEEP -> all outputs are at their reset values immediately, and the FSM is in IDLE after release.
